// File: rtl/spart_pkg.sv
// spart_pkg
// Shared definitions for the SPART bus master: register addresses on the
// SPART ioaddr bus, status-register bit positions, the baud divisor table
// and the driver FSM state encoding.
package spart_pkg;

  // SPART register map as seen on ioaddr
  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  // Status register bits: receive data available, transmit buffer ready
  localparam int STAT_RDA = 0;
  localparam int STAT_TBR = 1;

  // Divisors for 16x oversampling from a 50 MHz clock, indexed by br_sel
  // (00=4800, 01=9600, 10=19200, 11=38400)
  localparam logic [15:0] DIV_TABLE [0:3] = '{16'd650, 16'd324, 16'd162, 16'd80};

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CFG_LO,
    ST_CFG_HI,
    ST_POLL,
    ST_RD_RX,
    ST_WR_TX
  } state_t;

endpackage

// File: rtl/spart_fifo.sv
// spart_fifo
// Small synchronous byte FIFO used for both the RX and TX paths.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   push       write push_data at the clock edge (ignored when full)
//   push_data  byte to write
//   pop        drop the head entry at the clock edge (ignored when empty)
//   pop_data   head entry, 8'h00 while empty
//   full       DEPTH entries held
//   empty      no entries held
module spart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [0:DEPTH-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  // Stale storage is hidden so an empty FIFO always presents zero
  assign pop_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
  // push and pop leaves the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spart_driver.sv
// spart_driver
// Bus master for the SPART: programs the baud divisor, then repeatedly polls
// the status register, draining received bytes into an RX FIFO and feeding
// bytes from a TX FIFO. One bus access happens per clock cycle.
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   br_sel             baud select (00=4800 01=9600 10=19200 11=38400)
//   iocs, iorw, ioaddr SPART chip select, 1=read/0=write, register address
//   databus            bidirectional SPART data, driven only on writes
//   tx_valid, tx_byte  user byte offered for transmission
//   tx_ready           TX FIFO has room
//   rx_valid, rx_byte  RX FIFO head available
//   rx_ready           user consumes the RX head
//   cfg_busy           divisor programming in progress
module spart_driver #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_sel,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  input  logic       rx_ready,
  output logic       cfg_busy
);

  import spart_pkg::*;

  state_t     state;
  state_t     next_state;
  logic [1:0] br_sel_q;
  logic [7:0] bus_out;
  logic       rx_push;
  logic       tx_pop;
  logic       rx_full;
  logic       rx_empty;
  logic       tx_full;
  logic       tx_empty;
  logic [7:0] tx_head;

  spart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (databus),
    .pop       (rx_ready),
    .pop_data  (rx_byte),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  spart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid),
    .push_data (tx_byte),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign cfg_busy = (state == ST_INIT) || (state == ST_CFG_LO) || (state == ST_CFG_HI);

  // Only drive the shared bus while writing to the SPART
  assign databus = (iocs && !iorw) ? bus_out : 8'hzz;

  // br_sel_q remembers the rate being programmed so the high byte always
  // matches the low byte, even if br_sel moves mid-configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      br_sel_q <= 2'b00;
    end else begin
      state <= next_state;
      if (state == ST_CFG_LO) begin
        br_sel_q <= br_sel;
      end
    end
  end

  // Bus signals decode from state. POLL samples the status byte in the same
  // cycle it is read; reconfiguration wins over RX, and RX over TX.
  always_comb begin
    next_state = state;
    iocs       = 1'b0;
    iorw       = 1'b1;
    ioaddr     = ADDR_BUF;
    bus_out    = 8'h00;
    rx_push    = 1'b0;
    tx_pop     = 1'b0;
    case (state)
      ST_INIT: begin
        next_state = ST_CFG_LO;
      end
      ST_CFG_LO: begin
        iocs       = 1'b1;
        iorw       = 1'b0;
        ioaddr     = ADDR_DIV_LO;
        bus_out    = DIV_TABLE[br_sel][7:0];
        next_state = ST_CFG_HI;
      end
      ST_CFG_HI: begin
        iocs       = 1'b1;
        iorw       = 1'b0;
        ioaddr     = ADDR_DIV_HI;
        bus_out    = DIV_TABLE[br_sel_q][15:8];
        next_state = ST_POLL;
      end
      ST_POLL: begin
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = ADDR_STATUS;
        if (br_sel != br_sel_q) begin
          next_state = ST_CFG_LO;
        end else if (databus[STAT_RDA] && !rx_full) begin
          next_state = ST_RD_RX;
        end else if (databus[STAT_TBR] && !tx_empty) begin
          next_state = ST_WR_TX;
        end else begin
          next_state = ST_POLL;
        end
      end
      ST_RD_RX: begin
        iocs       = 1'b1;
        iorw       = 1'b1;
        ioaddr     = ADDR_BUF;
        rx_push    = 1'b1;
        next_state = ST_POLL;
      end
      ST_WR_TX: begin
        iocs       = 1'b1;
        iorw       = 1'b0;
        ioaddr     = ADDR_BUF;
        bus_out    = tx_head;
        tx_pop     = 1'b1;
        next_state = ST_POLL;
      end
      default: begin
        next_state = ST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver
// Drives spart_driver against a small behavioural SPART: status reads return
// {tbr, rda}, buffer reads return queued receive bytes. Every non-status bus
// access and every consumed RX byte is compared against expectation queues.
module tb_spart_driver;

  typedef struct packed {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_sel;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       cfg_busy;

  int checks   = 0;
  int failures = 0;

  acc_t       exp_q[$];
  logic [7:0] rx_exp[$];
  logic       prev_poll = 1'b0;

  // Behavioural SPART state
  logic       tbr;
  logic       rda_stuck;
  logic       rda;
  logic [7:0] spart_mem [0:7];
  logic [3:0] spart_rd = 4'd0;
  logic [3:0] spart_wr = 4'd0;
  logic [7:0] spart_dout;

  always #5 clk = ~clk;

  spart_driver #(.FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .br_sel   (br_sel),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .tx_valid (tx_valid),
    .tx_byte  (tx_byte),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ready (rx_ready),
    .cfg_busy (cfg_busy)
  );

  assign rda        = (spart_wr != spart_rd) || rda_stuck;
  assign spart_dout = (ioaddr == 2'b01) ? {6'd0, tbr, rda} :
                      ((spart_wr != spart_rd) ? spart_mem[spart_rd[2:0]] : 8'hEE);
  assign databus    = (iocs && iorw) ? spart_dout : 8'hzz;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expectAccess(input logic rw, input logic [1:0] addr, input logic [7:0] data);
    exp_q.push_back({rw, addr, data});
  endtask

  // Queue a byte in the SPART receiver and expect it to be read and delivered
  task automatic spartPush(input logic [7:0] b);
    spart_mem[spart_wr[2:0]] = b;
    spart_wr = spart_wr + 4'd1;
    expectAccess(1'b1, 2'b00, b);
    rx_exp.push_back(b);
  endtask

  // Offer one user TX byte for a single cycle
  task automatic applyStimulus(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_byte  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic waitQueueEmpty(input int max_cycles, input string name);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL %s: timeout with %0d accesses outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic waitBus(input logic rw, input logic [1:0] addr, input int max_cycles, input string name);
    bit found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (iocs && (iorw == rw) && (ioaddr == addr)) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL %s: access rw=%0b addr=%0b not seen, expected within %0d cycles", name, rw, addr, max_cycles);
    end
  endtask

  // SPART side effect: a buffer read consumes the head byte after the edge
  always @(negedge clk) begin
    if (!rst && iocs && iorw && (ioaddr == 2'b00)) begin
      @(posedge clk);
      #1;
      if (spart_rd != spart_wr) begin
        spart_rd = spart_rd + 4'd1;
      end
    end
  end

  // Monitor: checks every non-status bus access and every RX handshake
  always @(negedge clk) begin
    acc_t e;
    logic [7:0] b;
    if (rst) begin
      prev_poll = 1'b0;
    end else begin
      if (iocs && iorw && (ioaddr == 2'b01)) begin
        prev_poll = 1'b1;
      end else if (iocs) begin
        if (ioaddr == 2'b00) begin
          checkOutput("poll_before_buffer", 16'(prev_poll), 16'h0001);
        end
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL bus_access: unexpected rw=%0b addr=%0b data=%h, expected none", iorw, ioaddr, databus);
        end else begin
          e = exp_q.pop_front();
          checkOutput("bus_access", 16'({iorw, ioaddr, databus}), 16'(e));
        end
        prev_poll = 1'b0;
      end else begin
        prev_poll = 1'b0;
      end
      if (rx_valid && rx_ready) begin
        if (rx_exp.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL rx_pop: unexpected byte %h, expected none", rx_byte);
        end else begin
          b = rx_exp.pop_front();
          checkOutput("rx_pop", 16'(rx_byte), 16'(b));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    br_sel    = 2'b01;
    tx_valid  = 1'b0;
    tx_byte   = 8'h00;
    rx_ready  = 1'b0;
    tbr       = 1'b0;
    rda_stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values and the configuration sequence at 9600 baud
    checkOutput("rst_iocs", 16'(iocs), 16'h0000);
    checkOutput("rst_iorw", 16'(iorw), 16'h0001);
    checkOutput("rst_ioaddr", 16'(ioaddr), 16'h0000);
    checkOutput("rst_tx_ready", 16'(tx_ready), 16'h0001);
    checkOutput("rst_rx_valid", 16'(rx_valid), 16'h0000);
    checkOutput("rst_rx_byte", 16'(rx_byte), 16'h0000);
    checkOutput("rst_cfg_busy", 16'(cfg_busy), 16'h0001);
    expectAccess(1'b0, 2'b10, 8'h44);
    expectAccess(1'b0, 2'b11, 8'h01);
    rst = 1'b0;
    checkOutput("c1_iocs", 16'(iocs), 16'h0000);
    tick();
    checkOutput("c2_access", 16'({iocs, iorw, ioaddr, databus}), 16'({1'b1, 1'b0, 2'b10, 8'h44}));
    tick();
    checkOutput("c3_access", 16'({iocs, iorw, ioaddr, databus}), 16'({1'b1, 1'b0, 2'b11, 8'h01}));
    checkOutput("c3_cfg_busy", 16'(cfg_busy), 16'h0001);
    tick();
    checkOutput("c4_access", 16'({iocs, iorw, ioaddr}), 16'({1'b1, 1'b1, 2'b01}));
    checkOutput("c4_cfg_busy", 16'(cfg_busy), 16'h0000);

    // Single RX byte: read, present next cycle, pop
    spartPush(8'hA5);
    waitBus(1'b1, 2'b00, 10, "t2_rd_rx");
    tick();
    checkOutput("t2_rx_valid", 16'(rx_valid), 16'h0001);
    checkOutput("t2_rx_byte", 16'(rx_byte), 16'h00A5);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    checkOutput("t2_rx_valid_after_pop", 16'(rx_valid), 16'h0000);

    // Single TX byte: exactly one write
    tbr = 1'b1;
    expectAccess(1'b0, 2'b00, 8'h3C);
    applyStimulus(8'h3C);
    waitQueueEmpty(30, "t3_tx");
    repeat (8) tick();
    checkOutput("t3_tx_ready", 16'(tx_ready), 16'h0001);

    // TX FIFO fills while the SPART is busy; an offer while full is dropped
    tbr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expectAccess(1'b0, 2'b00, 8'h10 + 8'(i));
      applyStimulus(8'h10 + 8'(i));
    end
    checkOutput("txfull_ready", 16'(tx_ready), 16'h0000);
    applyStimulus(8'hFF);
    checkOutput("txfull_ready_hold", 16'(tx_ready), 16'h0000);
    tbr = 1'b1;
    waitQueueEmpty(60, "txfull_drain");
    repeat (8) tick();
    checkOutput("txfull_ready_after", 16'(tx_ready), 16'h0001);

    // RX FIFO full with rda stuck: no fifth read, TX still served
    rda_stuck = 1'b1;
    spartPush(8'h11);
    spartPush(8'h22);
    spartPush(8'h33);
    spartPush(8'h44);
    expectAccess(1'b0, 2'b00, 8'h77);
    applyStimulus(8'h77);
    checkOutput("t4_tx_ready", 16'(tx_ready), 16'h0001);
    waitQueueEmpty(80, "t4_accesses");
    repeat (10) tick();
    checkOutput("t4_rx_valid", 16'(rx_valid), 16'h0001);
    checkOutput("t4_rx_head", 16'(rx_byte), 16'h0011);
    checkOutput("t4_tx_ready_after", 16'(tx_ready), 16'h0001);
    rda_stuck = 1'b0;
    rx_ready  = 1'b1;
    repeat (4) tick();
    rx_ready = 1'b0;
    checkOutput("t4_rx_drained", 16'(rx_valid), 16'h0000);

    // Baud change while polling: 38400
    br_sel = 2'b11;
    expectAccess(1'b0, 2'b10, 8'h50);
    expectAccess(1'b0, 2'b11, 8'h00);
    waitQueueEmpty(20, "t5_cfg");
    checkOutput("t5_poll", 16'({iocs, iorw, ioaddr}), 16'({1'b1, 1'b1, 2'b01}));
    checkOutput("t5_cfg_busy", 16'(cfg_busy), 16'h0000);

    // Change to 4800, then to 19200 during the high-byte write
    br_sel = 2'b00;
    expectAccess(1'b0, 2'b10, 8'h8A);
    expectAccess(1'b0, 2'b11, 8'h02);
    expectAccess(1'b0, 2'b10, 8'hA2);
    expectAccess(1'b0, 2'b11, 8'h00);
    tick();
    tick();
    br_sel = 2'b10;
    waitQueueEmpty(20, "t5b_cfg");
    checkOutput("t5b_poll", 16'({iocs, iorw, ioaddr}), 16'({1'b1, 1'b1, 2'b01}));

    // Reset during a TX write, with an RX byte also held
    tbr = 1'b0;
    spartPush(8'h66);
    waitQueueEmpty(20, "t6_rx");
    tick();
    checkOutput("t6_rx_valid", 16'(rx_valid), 16'h0001);
    tbr = 1'b1;
    applyStimulus(8'h5A);
    waitBus(1'b0, 2'b00, 10, "t6_wr_tx");
    checkOutput("t6_wr_data", 16'(databus), 16'h005A);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_bus", 16'({iocs, iorw}), 16'({1'b0, 1'b1}));
    checkOutput("t6_rst_cfg_busy", 16'(cfg_busy), 16'h0001);
    checkOutput("t6_rst_tx_ready", 16'(tx_ready), 16'h0001);
    checkOutput("t6_rst_rx_valid", 16'(rx_valid), 16'h0000);
    checkOutput("t6_rst_rx_byte", 16'(rx_byte), 16'h0000);
    rx_exp.delete();
    expectAccess(1'b0, 2'b10, 8'hA2);
    expectAccess(1'b0, 2'b11, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    waitQueueEmpty(20, "t6_restart");
    checkOutput("t6_poll", 16'({iocs, iorw, ioaddr}), 16'({1'b1, 1'b1, 2'b01}));
    repeat (10) tick();

    checkOutput("end_bus_queue", 16'(exp_q.size()), 16'h0000);
    checkOutput("end_rx_queue", 16'(rx_exp.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
